// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU types and sizes for the register-file writeback path.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_NUM = 64;
  localparam int unsigned REG_AW  = $clog2(REG_NUM);
  localparam int unsigned WB_NREQ = 4;
  localparam int unsigned WE_W    = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [31:0]       uint32_t;
  typedef logic [WE_W-1:0]   byte_en_t;

  // One registered regfile write port payload.
  typedef struct packed {
    byte_en_t  we;
    reg_addr_t waddr;
    uint32_t   wdata;
  } wb_slot_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Combinational two-grant round-robin picker; slot 2 must target a different register than slot 1.
module rr_pick2
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = WB_NREQ,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  reg_addr_t       waddr [NREQ],
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant_c,
  output logic            s1_vld_c,
  output logic [IW-1:0]   s1_idx_c,
  output logic            s2_vld_c,
  output logic [IW-1:0]   s2_idx_c,
  output logic [IW-1:0]   next_ptr_c
);

  logic [IW-1:0] idx;
  logic [IW-1:0] last_idx;

  // Scan from ptr with wrap; same-address candidates are skipped for slot 2.
  always_comb begin
    grant_c    = '0;
    s1_vld_c   = 1'b0;
    s1_idx_c   = '0;
    s2_vld_c   = 1'b0;
    s2_idx_c   = '0;
    idx        = '0;
    last_idx   = '0;
    next_ptr_c = ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr) + k) % NREQ);
      if (valid[idx]) begin
        if (!s1_vld_c) begin
          s1_vld_c = 1'b1;
          s1_idx_c = idx;
        end else if (!s2_vld_c && (waddr[idx] != waddr[s1_idx_c])) begin
          s2_vld_c = 1'b1;
          s2_idx_c = idx;
        end
      end
    end
    if (s1_vld_c) begin
      grant_c[s1_idx_c] = 1'b1;
      last_idx          = s1_idx_c;
    end
    if (s2_vld_c) begin
      grant_c[s2_idx_c] = 1'b1;
      last_idx          = s2_idx_c;
    end
    if (s1_vld_c) begin
      next_ptr_c = IW'((32'(last_idx) + 32'd1) % NREQ);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the two regfile write ports with one cycle of latency.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = WB_NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  reg_addr_t       req_waddr [NREQ],
  input  logic [3:0]      req_we    [NREQ],
  input  uint32_t         req_wdata [NREQ],
  output logic [3:0]      inst1_we,
  output reg_addr_t       inst1_waddr,
  output uint32_t         inst1_wdata,
  output logic [3:0]      inst2_we,
  output reg_addr_t       inst2_waddr,
  output uint32_t         inst2_wdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant_c;
  logic            s1_vld_c;
  logic            s2_vld_c;
  logic [IW-1:0]   s1_idx_c;
  logic [IW-1:0]   s2_idx_c;
  logic [IW-1:0]   next_ptr_c;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_ptr_d;
  wb_slot_t        slot1_q;
  wb_slot_t        slot1_d;
  wb_slot_t        slot2_q;
  wb_slot_t        slot2_d;

  rr_pick2 #(.NREQ(NREQ)) u_pick (
    .valid      (req_valid),
    .waddr      (req_waddr),
    .ptr        (rr_ptr_q),
    .grant_c    (grant_c),
    .s1_vld_c   (s1_vld_c),
    .s1_idx_c   (s1_idx_c),
    .s2_vld_c   (s2_vld_c),
    .s2_idx_c   (s2_idx_c),
    .next_ptr_c (next_ptr_c)
  );

  assign req_ready = rst ? '0 : grant_c;

  // Empty slots keep address/data and only drop the enables; r0 writes are neutralised here.
  always_comb begin
    slot1_d    = slot1_q;
    slot1_d.we = '0;
    slot2_d    = slot2_q;
    slot2_d.we = '0;
    rr_ptr_d   = next_ptr_c;
    if (s1_vld_c) begin
      slot1_d.waddr = req_waddr[s1_idx_c];
      slot1_d.wdata = req_wdata[s1_idx_c];
      slot1_d.we    = (req_waddr[s1_idx_c] == '0) ? '0 : req_we[s1_idx_c];
    end
    if (s2_vld_c) begin
      slot2_d.waddr = req_waddr[s2_idx_c];
      slot2_d.wdata = req_wdata[s2_idx_c];
      slot2_d.we    = (req_waddr[s2_idx_c] == '0) ? '0 : req_we[s2_idx_c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot1_q  <= '0;
      slot2_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      slot1_q  <= slot1_d;
      slot2_q  <= slot2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign inst1_we    = slot1_q.we;
  assign inst1_waddr = slot1_q.waddr;
  assign inst1_wdata = slot1_q.wdata;
  assign inst2_we    = slot2_q.we;
  assign inst2_waddr = slot2_q.waddr;
  assign inst2_wdata = slot2_q.wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed checks of regfile_wb_arbiter against a queue-based arbitration model and a regfile.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  reg_addr_t       req_waddr [NREQ];
  logic [3:0]      req_we    [NREQ];
  uint32_t         req_wdata [NREQ];
  logic [3:0]      inst1_we, inst2_we;
  reg_addr_t       inst1_waddr, inst2_waddr;
  uint32_t         inst1_wdata, inst2_wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_we(req_we), .req_wdata(req_wdata),
    .inst1_we(inst1_we), .inst1_waddr(inst1_waddr), .inst1_wdata(inst1_wdata),
    .inst2_we(inst2_we), .inst2_waddr(inst2_waddr), .inst2_wdata(inst2_wdata)
  );

  function automatic uint32_t merge(uint32_t old, logic [3:0] we, uint32_t d);
    uint32_t r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Regfile driven by the DUT write ports.
  uint32_t rf [REG_NUM] = '{default: '0};
  always @(posedge clk) begin
    if (inst1_we != 4'b0) rf[inst1_waddr] <= merge(rf[inst1_waddr], inst1_we, inst1_wdata);
    if (inst2_we != 4'b0) rf[inst2_waddr] <= merge(rf[inst2_waddr], inst2_we, inst2_wdata);
  end

  // Reference model state.
  uint32_t         rf_m [REG_NUM] = '{default: '0};
  int              m_ptr;
  logic [3:0]      m_we1, m_we2;
  reg_addr_t       m_a1, m_a2;
  uint32_t         m_d1, m_d2;
  int              g1, g2;
  logic [NREQ-1:0] exp_ready;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_we1 = '0; m_we2 = '0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
    exp_ready = '0; g1 = -1; g2 = -1;
  endfunction

  // Candidates in rotated order; first one wins slot 1, first later one with another address wins slot 2.
  function automatic void model_pick();
    int q[$];
    g1 = -1; g2 = -1; exp_ready = '0;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) q.push_back((m_ptr + k) % NREQ);
    if (q.size() > 0) g1 = q[0];
    for (int j = 1; j < q.size(); j++)
      if (g2 < 0 && req_waddr[q[j]] != req_waddr[g1]) g2 = q[j];
    if (g1 >= 0) exp_ready[g1] = 1'b1;
    if (g2 >= 0) exp_ready[g2] = 1'b1;
  endfunction

  function automatic void model_commit();
    rf_m[m_a1] = merge(rf_m[m_a1], m_we1, m_d1);
    rf_m[m_a2] = merge(rf_m[m_a2], m_we2, m_d2);
    m_we1 = '0; m_we2 = '0;
    if (g1 >= 0) begin
      m_a1 = req_waddr[g1]; m_d1 = req_wdata[g1];
      m_we1 = (req_waddr[g1] == 0) ? 4'b0 : req_we[g1];
      m_ptr = (((g2 >= 0) ? g2 : g1) + 1) % NREQ;
    end
    if (g2 >= 0) begin
      m_a2 = req_waddr[g2]; m_d2 = req_wdata[g2];
      m_we2 = (req_waddr[g2] == 0) ? 4'b0 : req_we[g2];
    end
  endfunction

  // Called at a negedge with inputs driven; returns at the next negedge.
  task automatic step();
    reg_addr_t la1, la2;
    #1;
    model_pick();
    chk("ready", req_ready, exp_ready);
    @(posedge clk);
    #1;
    la1 = m_a1; la2 = m_a2;
    model_commit();
    chk("rf_p1", rf[la1], rf_m[la1]);
    chk("rf_p2", rf[la2], rf_m[la2]);
    chk("inst1_we", inst1_we, m_we1);
    chk("inst1_waddr", inst1_waddr, m_a1);
    chk("inst1_wdata", inst1_wdata, m_d1);
    chk("inst2_we", inst2_we, m_we2);
    chk("inst2_waddr", inst2_waddr, m_a2);
    chk("inst2_wdata", inst2_wdata, m_d2);
    chk("rr_ptr", dut.rr_ptr_q, m_ptr);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input int a, input logic [3:0] we, input uint32_t d);
    req_valid[i] = v; req_waddr[i] = reg_addr_t'(a); req_we[i] = we; req_wdata[i] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("rst_we1", inst1_we, 0);
    chk("rst_we2", inst2_we, 0);
    chk("rst_ptr", dut.rr_ptr_q, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    uint32_t dv [NREQ];
    int      lsu_wait;
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 4'h0, 32'h0);
    model_reset();
    #1;
    chk("por_we1", inst1_we, 0);
    chk("por_waddr1", inst1_waddr, 0);
    chk("por_wdata2", inst2_wdata, 0);
    req_valid = '1;
    #1;
    chk("rst_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Four distinct targets from pointer 0.
    for (int i = 0; i < NREQ; i++) begin
      dv[i] = $urandom;
      set_req(i, 1'b1, i + 1, 4'hF, dv[i]);
    end
    #1 chk("t34_ready", req_ready, 4'b0011);
    step();
    chk("t34_a1", inst1_waddr, 1);
    chk("t34_d1", inst1_wdata, dv[0]);
    chk("t34_a2", inst2_waddr, 2);
    chk("t34_d2", inst2_wdata, dv[1]);
    chk("t34_ptr", dut.rr_ptr_q, 2);
    req_valid = '0;
    step();

    // Address conflict: ALU1 is held behind ALU0 and lands one cycle later.
    apply_reset();
    dv[0] = $urandom; dv[1] = $urandom; dv[2] = $urandom;
    set_req(0, 1'b1, 5, 4'hF, dv[0]);
    set_req(1, 1'b1, 5, 4'hF, dv[1]);
    set_req(2, 1'b1, 6, 4'hF, dv[2]);
    #1 chk("t35_ready", req_ready, 4'b0101);
    step();
    chk("t35_a1", inst1_waddr, 5);
    chk("t35_d1", inst1_wdata, dv[0]);
    chk("t35_a2", inst2_waddr, 6);
    req_valid[0] = 1'b0; req_valid[2] = 1'b0;
    step();
    chk("t35_d1b", inst1_wdata, dv[1]);
    req_valid = '0;
    step();
    chk("t35_r5", rf[5], dv[1]);
    chk("t35_r6", rf[6], dv[2]);

    // r0 write is granted but produces no enable.
    apply_reset();
    set_req(3, 1'b1, 0, 4'hF, 32'hDEADBEEF);
    #1 chk("t36_ready", req_ready, 4'b1000);
    step();
    chk("t36_we1", inst1_we, 0);
    req_valid = '0;
    step();
    chk("t36_r0", rf[0], 0);

    // LSU must not starve behind saturated ALUs/MDU.
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, 4'hF, $urandom);
    lsu_wait = 99;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (req_ready[3] && lsu_wait == 99) lsu_wait = c;
      #0 step();
      for (int i = 0; i < 3; i++) if (exp_ready[i]) req_wdata[i] = $urandom;
    end
    chk("t37_lsu_in_3", (lsu_wait <= 3), 1);
    req_valid = '0;
    step();

    // Partial byte write merges into the prior value.
    apply_reset();
    set_req(0, 1'b1, 7, 4'hF, 32'h11223344);
    step();
    set_req(0, 1'b1, 7, 4'b0010, 32'hAABBCCDD);
    step();
    req_valid = '0;
    step();
    step();
    chk("t38_r7", rf[7], 32'h1122CC44);

    // Mid-operation reset drops a registered write.
    apply_reset();
    set_req(0, 1'b1, 9, 4'hF, 32'hCAFEF00D);
    step();
    chk("t39_pre_we", inst1_we, 4'hF);
    rst = 1'b1;
    #1;
    chk("t39_we1", inst1_we, 0);
    chk("t39_we2", inst2_we, 0);
    chk("t39_ptr", dut.rr_ptr_q, 0);
    chk("t39_ready", req_ready, 0);
    @(posedge clk);
    #1 chk("t39_r9", rf[9], 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 10, 4'hF, $urandom);
    #1 chk("t39_first", req_ready, 4'b0011);
    step();
    req_valid = '0;
    step();

    // Random traffic; requesters hold payload until granted.
    model_reset();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((req_valid[i] && exp_ready[i]) || !req_valid[i]) begin
          if ($urandom_range(0, 99) < 60)
            set_req(i, 1'b1, int'($urandom_range(0, 7)), 4'($urandom), $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
      step();
    end
    req_valid = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
